// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter_pkg
// Brief    : Shared state encodings and default sizing for the FIFO write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_wr_arbiter_pkg;

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_burst = 1'b1;

    localparam int c_def_width     = 16;
    localparam int c_def_n_req     = 4;
    localparam int c_def_burst_len = 4;

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; searches from last+1 upward.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int n_req    = 4,
    parameter int id_width = $clog2(n_req)
) (
    input  logic [n_req-1:0]    req,
    input  logic [id_width-1:0] last,
    output logic [n_req-1:0]    pick,
    output logic                valid
);

    // Offset k=n_req lands back on last, so the previous owner is the final candidate.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int k = 1; k <= n_req; k++) begin
            for (int i = 0; i < n_req; i++) begin
                if (!valid && req[i] && (i == (int'(last) + k) % n_req)) begin
                    pick[i] = 1'b1;
                    valid   = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter muxing n_req writers onto one FIFO write port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int width     = c_def_width,
    parameter int n_req     = c_def_n_req,
    parameter int burst_len = c_def_burst_len,
    parameter int id_width  = $clog2(n_req)
) (
    input  logic                     clk_w,
    input  logic                     reset,
    input  logic [n_req-1:0]         req,
    input  logic [n_req*width-1:0]   data_in,
    input  logic                     FIFO_full,
    output logic [n_req-1:0]         gnt,
    output logic [n_req-1:0]         accept,
    output logic                     wr_en,
    output logic [width-1:0]         data_out,
    output logic [id_width-1:0]      owner,
    output logic                     busy
);

    localparam logic [7:0] c_burst_cnt = 8'(burst_len);

    logic [0:0]          r_state;
    logic [n_req-1:0]    r_gnt;
    logic [id_width-1:0] r_last;
    logic [7:0]          r_beat_cnt;

    logic [0:0]          w_state_nxt;
    logic [n_req-1:0]    w_gnt_nxt;
    logic [id_width-1:0] w_last_nxt;
    logic [7:0]          w_beat_cnt_nxt;

    logic [n_req-1:0]    w_pick;
    logic                w_pick_valid;
    logic [id_width-1:0] w_pick_idx;
    logic [id_width-1:0] w_owner_idx;
    logic                w_owner_req;
    logic                w_tenure_end;

    rr_pick #(
        .n_req    (n_req),
        .id_width (id_width)
    ) u_rr_pick (
        .req   (req),
        .last  (r_last),
        .pick  (w_pick),
        .valid (w_pick_valid)
    );

    always_comb begin
        w_pick_idx  = '0;
        w_owner_idx = '0;
        for (int i = 0; i < n_req; i++) begin
            if (w_pick[i]) w_pick_idx = i[id_width-1:0];
            if (r_gnt[i])  w_owner_idx = i[id_width-1:0];
        end
    end

    assign w_owner_req  = |(r_gnt & req);
    assign w_tenure_end = (wr_en && (r_beat_cnt + 8'd1 == c_burst_cnt)) || !w_owner_req;
    assign gnt          = r_gnt;

    // last resets to n_req-1 so requester 0 is first in line after reset.
    always_ff @(posedge clk_w) begin
        if (reset) begin
            r_state    <= c_idle;
            r_gnt      <= '0;
            r_last     <= id_width'(n_req - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_last     <= w_last_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_last_nxt     = r_last;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            c_idle: begin
                if (w_pick_valid) begin
                    w_state_nxt    = c_burst;
                    w_gnt_nxt      = w_pick;
                    w_last_nxt     = w_pick_idx;
                    w_beat_cnt_nxt = '0;
                end
            end
            c_burst: begin
                if (wr_en) w_beat_cnt_nxt = r_beat_cnt + 8'd1;
                // Re-arbitrate on the ending edge itself so a waiting requester sees no bubble.
                if (w_tenure_end) begin
                    w_beat_cnt_nxt = '0;
                    if (w_pick_valid) begin
                        w_gnt_nxt  = w_pick;
                        w_last_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = c_idle;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        accept   = '0;
        wr_en    = 1'b0;
        data_out = '0;
        owner    = '0;
        busy     = 1'b0;
        if (!reset) begin
            accept = r_gnt & req & {n_req{~FIFO_full}};
            wr_en  = |accept;
            busy   = (r_state == c_burst);
            owner  = w_owner_idx;
            for (int i = 0; i < n_req; i++) begin
                if (r_gnt[i]) data_out = data_in[i*width +: width];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Self-checking bench: cycle vector table plus a FIFO scoreboard run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic        clk_w = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] data_in;
    logic        FIFO_full;
    logic [3:0]  gnt;
    logic [3:0]  accept;
    logic        wr_en;
    logic [15:0] data_out;
    logic [1:0]  owner;
    logic        busy;

    int errors = 0;
    int checks = 0;

    fifo_wr_arbiter #(
        .width     (16),
        .n_req     (4),
        .burst_len (4),
        .id_width  (2)
    ) dut (
        .clk_w     (clk_w),
        .reset     (reset),
        .req       (req),
        .data_in   (data_in),
        .FIFO_full (FIFO_full),
        .gnt       (gnt),
        .accept    (accept),
        .wr_en     (wr_en),
        .data_out  (data_out),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk_w = ~clk_w;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic [3:0] acc;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0]  gnt;
        logic [3:0]  acc;
        logic        wr;
        logic        busy;
        logic [1:0]  owner;
        logic [15:0] data;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic [15:0] fifo_q[$];

    task automatic add(input logic r, input logic [3:0] q, input logic f,
                       input logic [3:0] g, input logic [3:0] a, input logic b);
        vec_t v;
        v.rst = r; v.req = q; v.full = f; v.gnt = g; v.acc = a; v.busy = b;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    initial begin
        exp_t e;
        int sent[3];
        int rd_seq[3];
        int total_rd;
        bit done;

        // Rotation with all four requesting, four beats each
        add(1, 4'b1111, 0, 4'b0000, 4'b0000, 0);
        add(0, 4'b1111, 0, 4'b0000, 4'b0000, 0);
        for (int g = 0; g < 4; g++)
            repeat (4) add(0, 4'b1111, 0, 4'(1 << g), 4'(1 << g), 1);
        add(0, 4'b1111, 0, 4'b0001, 4'b0001, 1);
        // Owner 0 drops; requester 2 alone for ten beats with re-grants to itself
        add(0, 4'b0100, 0, 4'b0001, 4'b0000, 1);
        repeat (10) add(0, 4'b0100, 0, 4'b0100, 4'b0100, 1);
        // Requester 1: two beats, FIFO full five cycles, then two more beats
        add(0, 4'b0010, 0, 4'b0100, 4'b0000, 1);
        repeat (2) add(0, 4'b0010, 0, 4'b0010, 4'b0010, 1);
        repeat (5) add(0, 4'b0010, 1, 4'b0010, 4'b0000, 1);
        add(0, 4'b0010, 0, 4'b0010, 4'b0010, 1);
        add(0, 4'b1010, 0, 4'b0010, 4'b0010, 1);
        // Requester 3 sends one beat and drops while requester 0 waits
        add(0, 4'b1001, 0, 4'b1000, 4'b1000, 1);
        add(0, 4'b0001, 0, 4'b1000, 4'b0000, 1);
        add(0, 4'b0001, 0, 4'b0001, 4'b0001, 1);
        // Reset at beat_cnt=2 of requester 2, then 0101 restarts at requester 0
        add(0, 4'b0100, 0, 4'b0001, 4'b0000, 1);
        repeat (2) add(0, 4'b0100, 0, 4'b0100, 4'b0100, 1);
        add(1, 4'b0100, 0, 4'b0100, 4'b0000, 0);
        add(0, 4'b0101, 0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0101, 0, 4'b0001, 4'b0001, 1);

        reset = 1'b1; req = '0; FIFO_full = 1'b0; data_in = '0;
        repeat (3) @(posedge clk_w);

        for (int r = 0; r < vecs.size(); r++) begin
            @(posedge clk_w); #1;
            reset     = vecs[r].rst;
            req       = vecs[r].req;
            FIFO_full = vecs[r].full;
            for (int i = 0; i < 4; i++) data_in[i*16 +: 16] = {4'(i + 1), 12'(r)};
            e.gnt   = vecs[r].gnt;
            e.acc   = vecs[r].acc;
            e.wr    = |vecs[r].acc;
            e.busy  = vecs[r].busy;
            e.owner = vecs[r].rst ? 2'd0 : idx_of(vecs[r].gnt);
            e.data  = (vecs[r].rst || vecs[r].gnt == 4'b0) ? 16'h0
                      : {4'(idx_of(vecs[r].gnt)) + 4'd1, 12'(r)};
            sb.push_back(e);
            @(negedge clk_w);
            e = sb.pop_front();
            chk($sformatf("gnt[%0d]", r),      32'(gnt),      32'(e.gnt));
            chk($sformatf("accept[%0d]", r),   32'(accept),   32'(e.acc));
            chk($sformatf("wr_en[%0d]", r),    32'(wr_en),    32'(e.wr));
            chk($sformatf("busy[%0d]", r),     32'(busy),     32'(e.busy));
            chk($sformatf("owner[%0d]", r),    32'(owner),    32'(e.owner));
            chk($sformatf("data_out[%0d]", r), 32'(data_out), 32'(e.data));
        end

        // Three tagged writers into a depth-8 FIFO with a slow reader
        @(posedge clk_w); #1;
        reset = 1'b1; req = '0; FIFO_full = 1'b0;
        repeat (2) @(posedge clk_w);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin sent[i] = 0; rd_seq[i] = 0; end
        total_rd = 0;
        done = 1'b0;
        req = 4'b0111;
        for (int i = 0; i < 4; i++) data_in[i*16 +: 16] = {4'(i + 1), 12'd0};

        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clk_w);
            if (wr_en) begin
                int t;
                t = int'(data_out[15:12]) - 1;
                chk("fifo_no_write_when_full", 32'(FIFO_full), 32'd0);
                chk("fifo_accept_src", 32'(accept), (t >= 0 && t < 3) ? 32'(1 << t) : 32'hDEAD);
                fifo_q.push_back(data_out);
                if (t >= 0 && t < 3) sent[t]++;
            end
            if (fifo_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                logic [15:0] d;
                int t;
                d = fifo_q.pop_front();
                t = int'(d[15:12]) - 1;
                total_rd++;
                if (t >= 0 && t < 3) begin
                    chk("fifo_order", 32'(d[11:0]), 32'(rd_seq[t]));
                    rd_seq[t]++;
                end else begin
                    chk("fifo_tag", 32'(d[15:12]), 32'd1);
                end
            end
            FIFO_full = (fifo_q.size() >= 8);
            for (int i = 0; i < 3; i++) begin
                req[i] = (sent[i] < 6);
                data_in[i*16 +: 16] = {4'(i + 1), 12'(sent[i])};
            end
            done = (total_rd >= 18) && (fifo_q.size() == 0);
        end

        chk("fifo_completed", 32'(done), 32'd1);
        chk("fifo_total_beats", 32'(total_rd), 32'd18);
        for (int i = 0; i < 3; i++) chk($sformatf("fifo_beats_req%0d", i), 32'(rd_seq[i]), 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter width, default 16, meaning data bits per beat; it matches the FIFO width.
REQ-002 The block SHALL have parameter n_req, default 4, meaning the number of requesters; the legal range is 2..8.
REQ-003 The block SHALL have parameter burst_len, default 4, meaning the maximum beats per grant tenure; the legal range is 1..255.
REQ-004 The block SHALL have parameter id_width, default $clog2(n_req), meaning the owner index width.
REQ-005 The block SHALL use one clock, clk_w; reset is synchronous and active-high, named reset.
REQ-006 Ports:
- clk_w  input  1  write-domain clock.
- reset  input  1  synchronous active-high reset.
- req  input  n_req  per-requester write request, level, held while data is valid.
- data_in  input  n_req*width  requester i data on bits [i*width +: width].
- FIFO_full  input  1  FIFO full flag, write domain.
- gnt  output  n_req  registered one-hot grant, or all-zero.
- accept  output  n_req  beat taken this cycle from requester i.
- wr_en  output  1  FIFO write enable.
- data_out  output  width  FIFO write data.
- owner  output  id_width  index of the granted requester; 0 when idle.
- busy  output  1  high in state BURST.

Function
REQ-007 The FSM SHALL have exactly two states, IDLE and BURST, and SHALL leave reset in IDLE.
REQ-008 accept[i] SHALL equal gnt[i] & req[i] & ~FIFO_full (combinational); wr_en SHALL equal |accept.
REQ-009 data_out SHALL be data_in of the granted requester, and all-zero when gnt is 0; the latency from accept to FIFO write SHALL be zero cycles.
REQ-010 Round-robin pick: the winner SHALL be the first asserted req at index last+1, last+2, ... (mod n_req), where last is the index of the most recent grant owner.
REQ-011 IDLE with any req high: the next edge SHALL register the pick into gnt, load last with the winner index, clear beat_cnt, and enter BURST.
REQ-012 IDLE with no req: gnt SHALL stay 0 and the FSM SHALL stay in IDLE.
REQ-013 In BURST, each accept SHALL increment the 8-bit beat_cnt.
REQ-014 The tenure SHALL end on an accept that makes beat_cnt reach burst_len, or on any cycle where req[owner]=0.
REQ-015 At tenure end, the same edge SHALL re-arbitrate with zero bubble: a new pick goes to BURST, and no requests goes to IDLE.
REQ-016 The previous owner SHALL be the lowest priority in the re-arbitration of REQ-015, and it SHALL win only if it is the sole requester.
REQ-017 FIFO_full high in BURST SHALL hold gnt and beat_cnt and force accept=0 and wr_en=0; a tenure SHALL never end on FIFO_full alone.
REQ-018 Requester i dropping req while FIFO_full is high and it holds the grant SHALL end the tenure per REQ-014.
REQ-019 burst_len=1 SHALL rotate the grant after every accepted beat.
REQ-020 gnt SHALL never have more than one bit set, and accept SHALL never be high for a requester without a grant.

Reset
REQ-021 reset high at an edge SHALL force state=IDLE, gnt=0, beat_cnt=0, and last=n_req-1, so requester 0 wins first after reset.
REQ-022 While reset is high, or in the same cycle as a reset edge, outputs SHALL be accept=0, wr_en=0, data_out=0, owner=0, and busy=0.
REQ-023 A reset during BURST SHALL abandon the tenure without emitting any further wr_en; beats already written SHALL be kept in the FIFO.

Structure
REQ-024 A shared package/include SHALL hold the state encodings (IDLE=0, BURST=1) and the default width, n_req and burst_len, so that FIFO_asn instantiation sites agree on them.
REQ-025 The round-robin picker SHALL be one sub-module, rr_pick, that is combinational.
REQ-026 rr_pick SHALL take req and last and return a one-hot pick plus a valid flag.
REQ-027 The fifo_wr_arbiter top level SHALL hold the FSM, beat_cnt, last, and the data mux.

Verification
REQ-028 Scenario: reset, then req=4'b1111, FIFO_full=0 -> gnt=0001 for 4 beats, then 0010, 0100, 1000, and 0001, with wr_en high every cycle after the first grant.
REQ-029 Scenario: req=4'b0100 alone, held for 10 cycles -> gnt=0100, 10 accepts, and 2 zero-bubble re-grants to requester 2 at beats 4 and 8.
REQ-030 Scenario: requester 1 granted, FIFO_full=1 for 5 cycles mid-burst at beat_cnt=2 -> wr_en=0 for those cycles, gnt holds 0010, and the burst ends after 2 more accepts.
REQ-031 Scenario: requester 3 granted, req[3] drops after 1 beat with req[0]=1 -> the next cycle has gnt=0001 and the tenure has a single accepted beat.
REQ-032 Scenario: reset asserted at beat_cnt=2 of requester 2 -> the next cycle has gnt=0, wr_en=0, and busy=0; after release with req=4'b0101, the grant goes to requester 0 first.
REQ-033 Scenario: feed fifo_wr_arbiter into FIFO_asn (depth 8) with 3 requesters sending tagged data -> the read order shows per-requester order preserved, there are no lost or duplicate beats, and no write occurs while FIFO_full is high.
